// File: rtl/decode_pkg.sv
// Shared RV32I decode constants: opcodes, one-hot op bit indices (also used by the alu),
// and the immediate-format selector.
package decode_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int NUM_OPS_DEF = 37;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam int OH_LUI   = 0;
  localparam int OH_AUIPC = 1;
  localparam int OH_JAL   = 2;
  localparam int OH_JALR  = 3;
  localparam int OH_BEQ   = 4;
  localparam int OH_BNE   = 5;
  localparam int OH_BLT   = 6;
  localparam int OH_BGE   = 7;
  localparam int OH_BLTU  = 8;
  localparam int OH_BGEU  = 9;
  localparam int OH_LB    = 10;
  localparam int OH_LH    = 11;
  localparam int OH_LW    = 12;
  localparam int OH_LBU   = 13;
  localparam int OH_LHU   = 14;
  localparam int OH_SB    = 15;
  localparam int OH_SH    = 16;
  localparam int OH_SW    = 17;
  localparam int OH_ADDI  = 18;
  localparam int OH_SLTI  = 19;
  localparam int OH_SLTIU = 20;
  localparam int OH_XORI  = 21;
  localparam int OH_ORI   = 22;
  localparam int OH_ANDI  = 23;
  localparam int OH_SLLI  = 24;
  localparam int OH_SRLI  = 25;
  localparam int OH_SRAI  = 26;
  localparam int OH_ADD   = 27;
  localparam int OH_SUB   = 28;
  localparam int OH_SLL   = 29;
  localparam int OH_SLT   = 30;
  localparam int OH_SLTU  = 31;
  localparam int OH_XOR   = 32;
  localparam int OH_SRL   = 33;
  localparam int OH_SRA   = 34;
  localparam int OH_OR    = 35;
  localparam int OH_AND   = 36;

  typedef enum logic [2:0] {
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_SHAMT,
    FMT_NONE
  } imm_fmt_t;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate extraction for the RV32I formats; zero latency, no flow control.
module decode_stage_imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [31:7]     instr,
  input  imm_fmt_t        fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = 32'd0;
    case (fmt)
      FMT_I:     imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:     imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:     imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:     imm32 = {instr[31:12], 12'd0};
      FMT_J:     imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      FMT_SHAMT: imm32 = {27'd0, instr[24:20]};
      default:   imm32 = 32'd0;
    endcase
  end

  // Widening beyond 32 bits keeps the sign of the 32-bit immediate.
  assign imm = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

endmodule

// File: rtl/decode_stage.sv
// RV32I decode into a one-entry output register; 1-cycle accept-to-valid latency.
// in_ready = !out_valid || out_ready, so a consume and an accept can overlap; flush clears the entry.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NUM_OPS = NUM_OPS_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [XLEN-1:0]    in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OPS-1:0] out_onehot,
  output logic [4:0]         out_rs1,
  output logic [4:0]         out_rs2,
  output logic [4:0]         out_rd,
  output logic [XLEN-1:0]    out_imm,
  output logic [XLEN-1:0]    out_pc,
  output logic               out_rd_we,
  output logic               out_illegal
);

  typedef struct packed {
    logic [NUM_OPS-1:0] onehot;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic [XLEN-1:0]    imm;
    logic [XLEN-1:0]    pc;
    logic               rd_we;
    logic               illegal;
  } entry_t;

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic [NUM_OPS-1:0] dec_onehot;
  imm_fmt_t           dec_fmt;
  logic               dec_writes;
  logic [XLEN-1:0]    dec_imm;
  logic               accept;
  logic               valid_d, valid_q;
  entry_t             entry_d, entry_q;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  always_comb begin
    dec_onehot = '0;
    dec_fmt    = FMT_NONE;
    dec_writes = 1'b0;
    case (opcode)
      OPC_LUI:   begin dec_onehot[OH_LUI]   = 1'b1; dec_fmt = FMT_U; dec_writes = 1'b1; end
      OPC_AUIPC: begin dec_onehot[OH_AUIPC] = 1'b1; dec_fmt = FMT_U; dec_writes = 1'b1; end
      OPC_JAL:   begin dec_onehot[OH_JAL]   = 1'b1; dec_fmt = FMT_J; dec_writes = 1'b1; end
      OPC_JALR: begin
        dec_fmt = FMT_I; dec_writes = 1'b1;
        if (funct3 == 3'b000) dec_onehot[OH_JALR] = 1'b1;
      end
      OPC_BRANCH: begin
        dec_fmt = FMT_B;
        case (funct3)
          3'b000: dec_onehot[OH_BEQ]  = 1'b1;
          3'b001: dec_onehot[OH_BNE]  = 1'b1;
          3'b100: dec_onehot[OH_BLT]  = 1'b1;
          3'b101: dec_onehot[OH_BGE]  = 1'b1;
          3'b110: dec_onehot[OH_BLTU] = 1'b1;
          3'b111: dec_onehot[OH_BGEU] = 1'b1;
          default: ;
        endcase
      end
      OPC_LOAD: begin
        dec_fmt = FMT_I; dec_writes = 1'b1;
        case (funct3)
          3'b000: dec_onehot[OH_LB]  = 1'b1;
          3'b001: dec_onehot[OH_LH]  = 1'b1;
          3'b010: dec_onehot[OH_LW]  = 1'b1;
          3'b100: dec_onehot[OH_LBU] = 1'b1;
          3'b101: dec_onehot[OH_LHU] = 1'b1;
          default: ;
        endcase
      end
      OPC_STORE: begin
        dec_fmt = FMT_S;
        case (funct3)
          3'b000: dec_onehot[OH_SB] = 1'b1;
          3'b001: dec_onehot[OH_SH] = 1'b1;
          3'b010: dec_onehot[OH_SW] = 1'b1;
          default: ;
        endcase
      end
      OPC_OP_IMM: begin
        dec_fmt = FMT_I; dec_writes = 1'b1;
        case (funct3)
          3'b000: dec_onehot[OH_ADDI]  = 1'b1;
          3'b010: dec_onehot[OH_SLTI]  = 1'b1;
          3'b011: dec_onehot[OH_SLTIU] = 1'b1;
          3'b100: dec_onehot[OH_XORI]  = 1'b1;
          3'b110: dec_onehot[OH_ORI]   = 1'b1;
          3'b111: dec_onehot[OH_ANDI]  = 1'b1;
          3'b001: begin
            dec_fmt = FMT_SHAMT;
            if (funct7 == 7'b0000000) dec_onehot[OH_SLLI] = 1'b1;
          end
          default: begin
            dec_fmt = FMT_SHAMT;
            if (funct7 == 7'b0000000)      dec_onehot[OH_SRLI] = 1'b1;
            else if (funct7 == 7'b0100000) dec_onehot[OH_SRAI] = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        dec_writes = 1'b1;
        case ({funct7, funct3})
          10'b0000000_000: dec_onehot[OH_ADD]  = 1'b1;
          10'b0100000_000: dec_onehot[OH_SUB]  = 1'b1;
          10'b0000000_001: dec_onehot[OH_SLL]  = 1'b1;
          10'b0000000_010: dec_onehot[OH_SLT]  = 1'b1;
          10'b0000000_011: dec_onehot[OH_SLTU] = 1'b1;
          10'b0000000_100: dec_onehot[OH_XOR]  = 1'b1;
          10'b0000000_101: dec_onehot[OH_SRL]  = 1'b1;
          10'b0100000_101: dec_onehot[OH_SRA]  = 1'b1;
          10'b0000000_110: dec_onehot[OH_OR]   = 1'b1;
          10'b0000000_111: dec_onehot[OH_AND]  = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  decode_stage_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (in_instr[31:7]),
    .fmt   (dec_fmt),
    .imm   (dec_imm)
  );

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d         = 1'b1;
      entry_d.onehot  = dec_onehot;
      entry_d.rs1     = in_instr[19:15];
      entry_d.rs2     = in_instr[24:20];
      entry_d.rd      = in_instr[11:7];
      entry_d.imm     = dec_imm;
      entry_d.pc      = in_pc;
      entry_d.illegal = ~|dec_onehot;
      // An illegal op or an x0 destination never writes the register file.
      entry_d.rd_we   = dec_writes && (|dec_onehot) && (in_instr[11:7] != 5'd0);
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_onehot  = entry_q.onehot;
  assign out_rs1     = entry_q.rs1;
  assign out_rs2     = entry_q.rs2;
  assign out_rd      = entry_q.rd;
  assign out_imm     = entry_q.imm;
  assign out_pc      = entry_q.pc;
  assign out_rd_we   = entry_q.rd_we;
  assign out_illegal = entry_q.illegal;

endmodule
